// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the execute-stage ALU slice:
//   - default operand width and shift-amount width
//   - 4-bit ALU control codes (same values the ALU control decoder emits)
//   - state encoding for the sequential execution unit
package alu_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True for the two op codes that go through the iterative shifter.
  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == OP_SLL) || (code == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core
// Purely combinational single-cycle ALU operations.
// Ports:
//   alu_control  in   4-bit op code
//   operand_a    in   first operand
//   operand_b    in   second operand
//   result       out  AND/OR/ADD/SUB/SLT result; 0 for any other code
// Shift codes are handled elsewhere and produce 0 here.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] result
);

  // SLT is a signed compare whose single-bit answer is zero-extended.
  always_comb begin
    result = '0;
    unique case (alu_control)
      OP_AND:  result = operand_a & operand_b;
      OP_OR:   result = operand_a | operand_b;
      OP_ADD:  result = operand_a + operand_b;
      OP_SUB:  result = operand_a - operand_b;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec
// Multi-cycle execute unit: logic/arithmetic ops finish in one cycle, shifts
// run on a 1-bit-per-cycle iterative shifter. Valid/ready on both sides.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     request valid
//   in_ready     unit can accept a request (IDLE and not in reset)
//   alu_control  4-bit op code
//   operand_a    first operand / value to shift
//   operand_b    second operand; low SHAMT_W bits are the shift amount
//   out_valid    registered result valid
//   out_ready    consumer accepts result
//   alu_out      registered result, held while waiting for out_ready
//   zero         registered alu_out == 0
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero
);

  state_t               state;
  logic [3:0]           op;
  logic [DATA_W-1:0]    acc;
  logic [SHAMT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   shamt;
  logic [DATA_W-1:0]    comb_result;
  logic [DATA_W-1:0]    shifted;

  assign shamt = operand_b[SHAMT_W-1:0];

  alu_comb_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .result      (comb_result)
  );

  // Only IDLE can accept; reset also masks acceptance in its own cycle.
  assign in_ready = (state == ST_IDLE) && !rst;

  // One step of the iterative shifter; both directions fill with zero.
  assign shifted = (op == OP_SLL) ? {acc[DATA_W-2:0], 1'b0} : {1'b0, acc[DATA_W-1:1]};

  // Control FSM. Every output except in_ready is produced here so the result
  // side stays registered. The last shift step writes alu_out directly so the
  // result lands in the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op        <= OP_AND;
      acc       <= '0;
      cnt       <= '0;
      alu_out   <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op <= alu_control;
            if (is_shift_op(alu_control)) begin
              if (shamt == '0) begin
                alu_out   <= operand_a;
                zero      <= (operand_a == '0);
                out_valid <= 1'b1;
                state     <= ST_DONE;
              end else begin
                acc   <= operand_a;
                cnt   <= shamt;
                state <= ST_SHIFT;
              end
            end else begin
              alu_out   <= comb_result;
              zero      <= (comb_result == '0);
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          acc <= shifted;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            alu_out   <= shifted;
            zero      <= (shifted == '0);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec
// Table of {op, a, b, expected result} vectors driven through the handshake,
// with expected results queued at issue and compared when out_valid appears.
// Hand-written sequences cover backpressure in DONE and reset mid-shift.
module tb_alu_seq_exec;

  localparam logic [3:0] C_AND = 4'd0;
  localparam logic [3:0] C_OR  = 4'd1;
  localparam logic [3:0] C_ADD = 4'd2;
  localparam logic [3:0] C_SLL = 4'd3;
  localparam logic [3:0] C_SRL = 4'd4;
  localparam logic [3:0] C_SUB = 4'd6;
  localparam logic [3:0] C_SLT = 4'd7;
  localparam int         TIMEOUT = 100;
  localparam int         NVEC    = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        zero;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    int          latency;
  } sb_entry_t;

  vec_t      vecs [NVEC];
  sb_entry_t sb_queue [$];
  int        tests_run;
  int        tests_failed;

  alu_seq_exec dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_out     (alu_out),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one request for exactly one accepting edge
  // and optionally queues the expected result.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp,
                               input bit track);
    int waited;
    sb_entry_t e;
    waited = 0;
    while (!in_ready && waited < TIMEOUT) begin
      stepCycle();
      waited++;
    end
    compareValue("in_ready_before_issue", 32'(in_ready), 32'd1);
    alu_control = ctrl;
    operand_a   = a;
    operand_b   = b;
    in_valid    = 1'b1;
    stepCycle();
    in_valid = 1'b0;
    if (track) begin
      e.result  = exp;
      e.zero    = (exp == 32'd0);
      e.latency = ((ctrl == C_SLL) || (ctrl == C_SRL)) ? 1 + int'(b[4:0]) : 1;
      sb_queue.push_back(e);
    end
  endtask

  // Called one cycle after the accepting edge. Measures latency, checks the
  // result against the queue head, optionally holds out_ready low for
  // hold_cycles while poking in_valid, then checks the return to IDLE.
  task automatic checkOutput(input int hold_cycles);
    sb_entry_t e;
    int cycles;
    bit busy_ok;
    bit stable_ok;
    if (sb_queue.size() == 0) begin
      compareValue("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb_queue.pop_front();
    cycles  = 1;
    busy_ok = 1'b1;
    while (!out_valid && cycles < TIMEOUT) begin
      if (in_ready) busy_ok = 1'b0;
      stepCycle();
      cycles++;
    end
    if (in_ready) busy_ok = 1'b0;
    compareValue("out_valid_seen", 32'(out_valid), 32'd1);
    compareValue("latency", 32'(cycles), 32'(e.latency));
    compareValue("alu_out", alu_out, e.result);
    compareValue("zero", 32'(zero), 32'(e.zero));
    compareValue("in_ready_low_while_busy", 32'(busy_ok), 32'd1);
    if (hold_cycles > 0) begin
      stable_ok = 1'b1;
      for (int i = 0; i < hold_cycles; i++) begin
        in_valid    = i[0];
        alu_control = C_ADD;
        operand_a   = $urandom;
        operand_b   = $urandom;
        stepCycle();
        if (!out_valid || alu_out !== e.result || zero !== e.zero || in_ready)
          stable_ok = 1'b0;
      end
      in_valid  = 1'b0;
      compareValue("backpressure_stable", 32'(stable_ok), 32'd1);
      out_ready = 1'b1;
    end
    stepCycle();
    compareValue("out_valid_after_handshake", 32'(out_valid), 32'd0);
    compareValue("in_ready_after_handshake", 32'(in_ready), 32'd1);
    if (hold_cycles > 0) begin
      stepCycle();
      compareValue("no_accept_during_hold", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    alu_control  = C_AND;
    operand_a    = '0;
    operand_b    = '0;

    vecs[0]  = '{C_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
    vecs[1]  = '{C_SUB, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000};
    vecs[2]  = '{C_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[3]  = '{C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[4]  = '{C_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5]  = '{4'd5,  32'h0000_1234, 32'h0000_5678, 32'h0000_0000};
    vecs[6]  = '{C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
    vecs[7]  = '{C_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
    vecs[8]  = '{C_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
    vecs[9]  = '{4'd15, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000};
    vecs[10] = '{C_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
    vecs[11] = '{C_SLL, 32'h0000_0001, 32'd31,        32'h8000_0000};
    vecs[12] = '{C_SRL, 32'h8000_0000, 32'd4,         32'h0800_0000};
    vecs[13] = '{C_SLL, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF};
    vecs[14] = '{C_SRL, 32'hFFFF_FFFF, 32'd1,         32'h7FFF_FFFF};
    vecs[15] = '{C_SLL, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030};

    // Reset state, with in_valid asserted alongside rst to show no accept.
    in_valid = 1'b1;
    alu_control = C_ADD;
    operand_a = 32'd1;
    operand_b = 32'd1;
    stepCycle();
    compareValue("reset_in_ready", 32'(in_ready), 32'd0);
    compareValue("reset_out_valid", 32'(out_valid), 32'd0);
    compareValue("reset_alu_out", alu_out, 32'd0);
    compareValue("reset_zero", 32'(zero), 32'd0);
    stepCycle();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    compareValue("post_reset_in_ready", 32'(in_ready), 32'd1);
    stepCycle();
    compareValue("post_reset_no_accept", 32'(out_valid), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      checkOutput(0);
    end

    // Backpressure: result held for 10 cycles with in_valid pulses ignored.
    out_ready = 1'b0;
    applyStimulus(C_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b1);
    checkOutput(10);

    // Reset during a long shift discards it; a following ADD still works.
    applyStimulus(C_SLL, 32'h0000_0001, 32'd20, 32'h0010_0000, 1'b0);
    for (int i = 0; i < 5; i++) stepCycle();
    compareValue("mid_shift_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    #1;
    compareValue("abort_out_valid", 32'(out_valid), 32'd0);
    compareValue("abort_alu_out", alu_out, 32'd0);
    compareValue("abort_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(C_ADD, 32'h0000_0009, 32'h0000_0006, 32'h0000_000F, 1'b1);
    checkOutput(0);

    compareValue("scoreboard_drained", 32'(sb_queue.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Multi-cycle execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands, and returns a registered result. Logic and arithmetic ops complete in one cycle. Shifts run on an iterative 1-bit/cycle shifter, so the unit needs valid/ready handshakes on both sides. It sits in the execute stage between the operand muxes and the result/writeback path.

## Interface
- DATA_W, 32, operand/result width
- SHAMT_W, 5, shift-amount width (log2 DATA_W)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- alu_control  in  4  op code: AND=0, OR=1, ADD=2, SLL=3, SRL=4, SUB=6, SLT=7
- operand_a  in  DATA_W  first operand; the value shifted for SLL/SRL
- operand_b  in  DATA_W  second operand; bits [SHAMT_W-1:0] are the shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- alu_out  out  DATA_W  result
- zero  out  1  alu_out == 0, meaningful only while out_valid

## Operation
- States: IDLE, SHIFT, DONE. Reset and all unused states go to IDLE.
- in_ready = (state == IDLE) & ~rst.
- Accept when in_valid & in_ready. Capture alu_control, operand_a and shamt = operand_b[SHAMT_W-1:0].
- IDLE, accepted non-shift op: compute the result and go to DONE.
  - AND/OR: bitwise.
  - ADD/SUB: modulo 2^DATA_W, no carry or overflow out.
  - SLT: signed compare; result 1 if a < b, else 0, zero-extended.
  - Undefined codes (5, 8–15): result 0.
- IDLE, accepted SLL/SRL with shamt=0: result = operand_a, go to DONE.
- IDLE, accepted SLL/SRL with shamt>0: acc <= operand_a, cnt <= shamt, go to SHIFT.
- SHIFT: each cycle shift acc by 1 (SLL fills 0 at LSB; SRL is logical, fills 0 at MSB) and decrement cnt. The edge where cnt==1 loads the final value into alu_out and moves to DONE.
- DONE: out_valid=1. alu_out and zero stay stable until out_ready. When out_ready=1, go to IDLE.
- in_valid while busy is ignored, since in_ready=0. The producer holds its request.

## Timing
- Reset values: out_valid=0, alu_out=0, zero=0, in_ready=0 during the rst cycle, state=IDLE.
- Latency is measured from the acceptance cycle to the first out_valid cycle:
  - non-shift ops and shamt=0 shifts: 1 cycle
  - shifts: 1 + shamt cycles, so shamt=31 gives 32 cycles
- Minimum throughput is one op per 2 cycles. in_ready rises the cycle after the out_valid & out_ready handshake.
- out_ready held high in DONE: the result is consumed in its first valid cycle.
- rst asserted in any state aborts the in-flight op and discards its result. The next cycle is IDLE with out_valid=0.
- in_valid and rst high together: no accept.
- All outputs except in_ready are registered. in_ready is a decode of the state register.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit op-code constants (identical values to the decoder's outputs)
  - the state encoding (IDLE/SHIFT/DONE)
  - DATA_W/SHAMT_W defaults
- Single-cycle result logic lives in sub-module alu_comb_core (AND/OR/ADD/SUB/SLT, pure combinational).
- The FSM, counter and iterative shifter stay in alu_seq_exec.

## Test plan
- ADD a=0x0000_0005, b=0x0000_0003, out_ready=1 -> out_valid 1 cycle after accept, alu_out=0x8, zero=0, in_ready back high the following cycle.
- SUB a=7, b=7 -> alu_out=0, zero=1. ADD a=0xFFFF_FFFF, b=1 -> alu_out=0, zero=1 (wrap).
- SLT a=0xFFFF_FFFF (-1), b=1 -> alu_out=1. SLT a=1, b=0xFFFF_FFFF -> alu_out=0. Code 5 -> alu_out=0.
- Shift results and latencies:
  - SLL a=0x1, b=31 -> alu_out=0x8000_0000 after 32 cycles, in_ready=0 throughout
  - SRL a=0x8000_0000, b=4 -> alu_out=0x0800_0000 after 5 cycles
  - SLL b=0x20 (shamt=0) -> alu_out=a after 1 cycle
- Backpressure: out_ready=0 for 10 cycles in DONE -> alu_out/zero/out_valid stable. in_valid pulses during that window are not accepted. out_ready=1 -> IDLE next cycle.
- rst pulsed mid-SHIFT (SLL shamt=20, rst at cycle 6) -> next cycle out_valid=0, alu_out=0, in_ready=1. A new ADD issued then completes correctly in 1 cycle.
